// File: rtl/tc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tc_pkg
//  Purpose  : Shared definitions for the memory-mapped timer/counter:
//             FSM state encoding, register offsets, CTRL bit positions and
//             mode constants.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package tc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } tc_state_e;

    // Register offsets, taken from Addr[1:0]
    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // Mode field values; 2 and 3 are treated as one-shot
    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

endpackage : tc_pkg
`default_nettype wire

// File: rtl/timer_counter.sv
`default_nettype none
// ============================================================================
//  Module   : timer_counter
//  Purpose  : Programmable down-counter with one-shot / auto-reload modes and
//             a maskable interrupt, accessed through a small register map
//             (CTRL, PRESET, COUNT).
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset
//             Addr   - word address; only Addr[1:0] is decoded
//             WE     - write strobe (already address-qualified upstream)
//             Din    - write data
//             Dout   - read data, combinational on Addr
//             IRQ    - interrupt request (IM & irq_flag)
//  Revision : 1.0 - initial release
// ============================================================================
module timer_counter
    import tc_pkg::*;
#(
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q;
    logic              irq_flag_q, irq_flag_d;
    tc_state_e         state_q;

    logic              w_en;
    logic              w_reload;
    logic              w_ctrl_wr;
    logic              w_preset_wr;
    logic              w_fsm_set_irq;
    logic              w_fsm_clr_irq;
    logic              w_fsm_clr_en;
    logic              w_unused;

    assign w_en        = ctrl_q[CTRL_EN];
    // Only mode 1 reloads; modes 0, 2 and 3 all behave as one-shot.
    assign w_reload    = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);
    assign w_ctrl_wr   = WE && (Addr[1:0] == OFF_CTRL);
    assign w_preset_wr = WE && (Addr[1:0] == OFF_PRESET);

    // Side effects the FSM asks of the register file on this edge.
    // A count of 0 is treated like 1 so PRESET=0 still terminates.
    assign w_fsm_set_irq = (state_q == ST_CNT) && w_en && (count_q <= CNT_W'(1));
    assign w_fsm_clr_irq = (state_q == ST_INT) && w_reload;
    assign w_fsm_clr_en  = (state_q == ST_INT) && !w_reload;

    // Upper address bits are decoded upstream by the bridge.
    assign w_unused = ^Addr[29:2];

    // ------------------------------------------------------------------
    // Register file next-state: CPU writes take priority over FSM updates
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;

        if (w_fsm_clr_en) begin
            ctrl_d[CTRL_EN] = 1'b0;
        end
        if (w_fsm_set_irq) begin
            irq_flag_d = 1'b1;
        end
        if (w_fsm_clr_irq) begin
            irq_flag_d = 1'b0;
        end

        if (w_ctrl_wr) begin
            ctrl_d     = Din[CTRL_W-1:0];
            irq_flag_d = 1'b0;
        end
        if (w_preset_wr) begin
            preset_d = Din[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            preset_q   <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // ------------------------------------------------------------------
    // Counter FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_en) begin
                        state_q <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    count_q <= preset_q;
                    state_q <= ST_CNT;
                end
                ST_CNT: begin
                    if (!w_en) begin
                        // Disabled mid-count: COUNT freezes where it is.
                        state_q <= ST_IDLE;
                    end else if (count_q > CNT_W'(1)) begin
                        count_q <= count_q - CNT_W'(1);
                    end else begin
                        count_q <= '0;
                        state_q <= ST_INT;
                    end
                end
                ST_INT: begin
                    // In reload mode Enable is still set, so IDLE goes
                    // straight back to LOAD on the following edge.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read mux and interrupt output
    // ------------------------------------------------------------------
    always_comb begin
        Dout = 32'h0;
        case (Addr[1:0])
            OFF_CTRL:   Dout = 32'(ctrl_q);
            OFF_PRESET: Dout = 32'(preset_q);
            OFF_COUNT:  Dout = 32'(count_q);
            default:    Dout = 32'h0;
        endcase
    end

    assign IRQ = ctrl_q[CTRL_IM] & irq_flag_q;

endmodule : timer_counter
`default_nettype wire
